hex_glyph_render: RTL and testbench



---
 rtl/glyph_pkg.sv | 29 ++
 rtl/blink_timer.sv | 39 +++
 rtl/hex_glyph_render.sv | 116 +++++++++++
 tb/tb_hex_glyph_render.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_pkg.sv
// rtl/glyph_pkg.sv - shared glyph geometry, stage-1 record and bit-index helper
package glyph_pkg;

   localparam int GLYPH_W    = 3;
   localparam int GLYPH_H    = 5;
   localparam int GLYPH_BITS = 15;

   // Where a pixel falls horizontally within the two-digit strip
   typedef enum logic [1:0] {
      REGION_OUT   = 2'd0,
      REGION_LEFT  = 2'd1,
      REGION_GAP   = 2'd2,
      REGION_RIGHT = 2'd3
   } region_t;

   // Decoded pixel carried from the coordinate stage to the bitmap stage
   typedef struct packed {
      logic    valid;
      region_t region;
      logic [1:0] col;
      logic [2:0] row;
   } stage1_t;

   // Row r occupies bits [14-3r : 12-3r]; column c is the c-th bit up from the row's low end
   function automatic logic [3:0] glyph_bit(input logic [2:0] row, input logic [1:0] col);
      return 4'(12 - 3 * int'(row) + int'(col));
   endfunction

endpackage

// File: rtl/blink_timer.sv
// rtl/blink_timer.sv - frame-counted blink phase with pre-update visibility flag
module blink_timer #(
   parameter int BLINK_FRAMES = 30
) (
   input  logic clk,
   input  logic reset,
   input  logic frame_start,
   input  logic blink_en,
   output logic vis
);

   localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

   logic [CW-1:0] cnt;
   logic          ph;

   // Visibility is taken from the phase before this frame's update is applied
   assign vis = blink_en ? ~ph : 1'b1;

   // Count frames while blinking; hold the counter cleared while blinking is off
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         ph  <= 1'b0;
      end else if (!blink_en) begin
         cnt <= '0;
         ph  <= 1'b0;
      end else if (frame_start) begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            ph  <= ~ph;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/hex_glyph_render.sv
// rtl/hex_glyph_render.sv - two-digit 3x5 hex glyph rasteriser with frame shadowing and blink
module hex_glyph_render
   import glyph_pkg::*;
#(
   parameter int SCALE        = 3,
   parameter int ORIGIN_X     = 0,
   parameter int ORIGIN_Y     = 0,
   parameter int GAP          = 1,
   parameter int BLINK_FRAMES = 30,
   parameter int COORD_W      = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_start,
   input  logic [GLYPH_BITS-1:0] letter_left,
   input  logic [GLYPH_BITS-1:0] letter_right,
   input  logic                  blink_en,
   input  logic                  pix_valid,
   input  logic [COORD_W-1:0]    pix_x,
   input  logic [COORD_W-1:0]    pix_y,
   output logic                  pix_out_valid,
   output logic                  pix_on
);

   // One extra bit so the origin subtraction and comparisons never wrap
   localparam int AW = COORD_W + 1;
   localparam logic [AW-1:0] OX          = AW'(ORIGIN_X);
   localparam logic [AW-1:0] OY          = AW'(ORIGIN_Y);
   localparam logic [AW-1:0] CY_MAX      = AW'(GLYPH_H - 1);
   localparam logic [AW-1:0] LEFT_MAX    = AW'(GLYPH_W - 1);
   localparam logic [AW-1:0] RIGHT_START = AW'(GLYPH_W + GAP);
   localparam logic [AW-1:0] CX_MAX      = AW'(2 * GLYPH_W - 1 + GAP);

   logic [AW-1:0]         px, py, dx, dy, cx, cy;
   logic [1:0]            rcol;
   stage1_t               s1_next, s1;
   logic [GLYPH_BITS-1:0] sh_left, sh_right, sel_bitmap;
   logic                  sh_vis, vis, glyph_lit;

   blink_timer #(
      .BLINK_FRAMES(BLINK_FRAMES)
   ) u_blink (
      .clk        (clk),
      .reset      (reset),
      .frame_start(frame_start),
      .blink_en   (blink_en),
      .vis        (vis)
   );

   // Map screen coordinates to a glyph cell and classify it
   always_comb begin
      px      = {1'b0, pix_x};
      py      = {1'b0, pix_y};
      dx      = px - OX;
      dy      = py - OY;
      cx      = dx >> SCALE;
      cy      = dy >> SCALE;
      rcol    = 2'(cx - RIGHT_START);
      s1_next = '0;
      s1_next.valid = pix_valid;
      if (px < OX || py < OY || cy > CY_MAX || cx > CX_MAX) begin
         s1_next.region = REGION_OUT;
      end else if (cx <= LEFT_MAX) begin
         s1_next.region = REGION_LEFT;
         s1_next.col    = cx[1:0];
         s1_next.row    = cy[2:0];
      end else if (cx < RIGHT_START) begin
         s1_next.region = REGION_GAP;
      end else begin
         s1_next.region = REGION_RIGHT;
         s1_next.col    = rcol;
         s1_next.row    = cy[2:0];
      end
   end

   // Stage 1: register the decoded pixel
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= '0;
      end else begin
         s1 <= s1_next;
      end
   end

   // Frame shadows: bitmaps and visibility only change at frame_start
   always_ff @(posedge clk) begin
      if (reset) begin
         sh_left  <= '0;
         sh_right <= '0;
         sh_vis   <= 1'b1;
      end else if (frame_start) begin
         sh_left  <= letter_left;
         sh_right <= letter_right;
         sh_vis   <= vis;
      end
   end

   // Pick the digit bitmap and the addressed bit; row/col are zero outside a digit
   always_comb begin
      sel_bitmap = (s1.region == REGION_RIGHT) ? sh_right : sh_left;
      glyph_lit  = sel_bitmap[glyph_bit(s1.row, s1.col)];
   end

   // Stage 2: register the pixel result, blank whenever the output is not valid
   always_ff @(posedge clk) begin
      if (reset) begin
         pix_out_valid <= 1'b0;
         pix_on        <= 1'b0;
      end else begin
         pix_out_valid <= s1.valid;
         pix_on        <= s1.valid && sh_vis && glyph_lit &&
                          (s1.region == REGION_LEFT || s1.region == REGION_RIGHT);
      end
   end

endmodule

// File: tb/tb_hex_glyph_render.sv
// tb/tb_hex_glyph_render.sv - scoreboard bench for hex_glyph_render
module tb_hex_glyph_render;

   logic        clk = 1'b0;
   logic        reset, frame_start, blink_en, pix_valid, pix_valid2;
   logic [14:0] letter_left, letter_right;
   logic [9:0]  pix_x, pix_y;
   logic        pov, pon, pov2, pon2;
   logic        mon_en = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int next_id = 0;

   typedef struct {
      logic exp;
      int   cyc;
      int   id;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   hex_glyph_render #(
      .SCALE(3), .ORIGIN_X(0), .ORIGIN_Y(0), .GAP(1), .BLINK_FRAMES(2), .COORD_W(10)
   ) u_dut (
      .clk(clk), .reset(reset), .frame_start(frame_start),
      .letter_left(letter_left), .letter_right(letter_right), .blink_en(blink_en),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
      .pix_out_valid(pov), .pix_on(pon)
   );

   hex_glyph_render #(
      .SCALE(3), .ORIGIN_X(100), .ORIGIN_Y(0), .GAP(1), .BLINK_FRAMES(30), .COORD_W(10)
   ) u_dut_ox (
      .clk(clk), .reset(reset), .frame_start(frame_start),
      .letter_left(letter_left), .letter_right(letter_right), .blink_en(blink_en),
      .pix_valid(pix_valid2), .pix_x(pix_x), .pix_y(pix_y),
      .pix_out_valid(pov2), .pix_on(pon2)
   );

   task automatic send(input int x, input int y, input logic exp, input logic fs);
      @(posedge clk); #1;
      pix_x = 10'(x); pix_y = 10'(y);
      pix_valid = 1'b1; pix_valid2 = 1'b0; frame_start = fs;
      q1.push_back('{exp: exp, cyc: cyc + 2, id: next_id});
      next_id++;
   endtask

   task automatic send2(input int x, input int y, input logic exp);
      @(posedge clk); #1;
      pix_x = 10'(x); pix_y = 10'(y);
      pix_valid = 1'b0; pix_valid2 = 1'b1; frame_start = 1'b0;
      q2.push_back('{exp: exp, cyc: cyc + 2, id: next_id});
      next_id++;
   endtask

   task automatic idle();
      @(posedge clk); #1;
      pix_valid = 1'b0; pix_valid2 = 1'b0; frame_start = 1'b0;
   endtask

   task automatic pulse_fs();
      @(posedge clk); #1;
      pix_valid = 1'b0; pix_valid2 = 1'b0; frame_start = 1'b1;
   endtask

   // Monitor for the origin-(0,0) instance
   always @(negedge clk) begin
      if (mon_en) begin
         if (pov === 1'b1) begin
            total++;
            if (q1.size() == 0) begin
               bad++;
               $display("FAIL dut_unexpected_valid: pix_out_valid=1 at cycle %0d, need 0", cyc);
            end else begin
               exp_t e;
               e = q1.pop_front();
               if (pon !== e.exp || cyc != e.cyc) begin
                  bad++;
                  $display("FAIL dut_pix%0d: pix_on=%b at cycle %0d, need %b at cycle %0d",
                           e.id, pon, cyc, e.exp, e.cyc);
               end
            end
         end else begin
            if (pon !== 1'b0) begin
               total++; bad++;
               $display("FAIL dut_blank: pix_on=%b with pix_out_valid=%b at cycle %0d, need 0", pon, pov, cyc);
            end
            if (q1.size() > 0 && q1[0].cyc < cyc) begin
               exp_t e;
               e = q1.pop_front();
               total++; bad++;
               $display("FAIL dut_pix%0d_missing: no output by cycle %0d, need at cycle %0d", e.id, cyc, e.cyc);
            end
         end
      end
   end

   // Monitor for the origin-(100,0) instance
   always @(negedge clk) begin
      if (mon_en) begin
         if (pov2 === 1'b1) begin
            total++;
            if (q2.size() == 0) begin
               bad++;
               $display("FAIL ox_unexpected_valid: pix_out_valid=1 at cycle %0d, need 0", cyc);
            end else begin
               exp_t e;
               e = q2.pop_front();
               if (pon2 !== e.exp || cyc != e.cyc) begin
                  bad++;
                  $display("FAIL ox_pix%0d: pix_on=%b at cycle %0d, need %b at cycle %0d",
                           e.id, pon2, cyc, e.exp, e.cyc);
               end
            end
         end else begin
            if (pon2 !== 1'b0) begin
               total++; bad++;
               $display("FAIL ox_blank: pix_on=%b at cycle %0d, need 0", pon2, cyc);
            end
            if (q2.size() > 0 && q2[0].cyc < cyc) begin
               exp_t e;
               e = q2.pop_front();
               total++; bad++;
               $display("FAIL ox_pix%0d_missing: no output by cycle %0d, need at cycle %0d", e.id, cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      total++; bad++;
      $display("FAIL timeout: simulation still running at %0t, need finish", $time);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      reset = 1'b1; frame_start = 1'b0; blink_en = 1'b0;
      pix_valid = 1'b0; pix_valid2 = 1'b0; pix_x = '0; pix_y = '0;
      letter_left = '0; letter_right = '0;
      @(posedge clk); #1; mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      total++;
      if (pov !== 1'b0 || pon !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: valid=%b on=%b, need 0 0", pov, pon);
      end

      // Shadows are zero after reset, so nothing lights before the first frame
      send(0, 0, 1'b0, 1'b0);
      idle();

      // Load "0" and "1"; the frame_start-cycle pixel already sees them
      letter_left  = 15'b111101101101111;
      letter_right = 15'b100100100100100;
      send(0, 0, 1'b1, 1'b1);
      send(8, 8, 1'b0, 1'b0);
      send(24, 0, 1'b0, 1'b0);
      send(32, 0, 1'b0, 1'b0);
      send(48, 0, 1'b1, 1'b0);
      send(56, 0, 1'b0, 1'b0);
      send(0, 40, 1'b0, 1'b0);
      send(16, 32, 1'b1, 1'b0);
      send(40, 32, 1'b0, 1'b0);
      idle();

      // Isolated pixel: monitor checks it appears exactly two cycles later
      repeat (3) idle();
      send(48, 8, 1'b1, 1'b0);
      repeat (4) idle();

      // Tearing: a mid-frame bitmap change is ignored until frame_start
      letter_left = 15'h7fff;
      send(8, 8, 1'b0, 1'b0);
      idle();
      send(8, 8, 1'b0, 1'b0);
      send(8, 8, 1'b1, 1'b1);
      send(8, 8, 1'b1, 1'b0);
      idle();

      // Blink with a two-frame half period
      blink_en = 1'b1;
      for (int f = 1; f <= 6; f++) begin
         pulse_fs();
         send(0, 0, (f <= 2 || f >= 5) ? 1'b1 : 1'b0, 1'b0);
         idle();
      end
      // Phase would be dark on frame 7; disabling blink makes it lit
      blink_en = 1'b0;
      pulse_fs();
      send(0, 0, 1'b1, 1'b0);
      idle();
      repeat (2) idle();

      // Reset with two pixels in flight: both are flushed
      @(posedge clk); #1;
      pix_x = '0; pix_y = '0; pix_valid = 1'b1;
      @(posedge clk); #1;
      pix_valid = 1'b1; reset = 1'b1;
      @(posedge clk); #1;
      pix_valid = 1'b0; reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         total++;
         if (pov !== 1'b0 || pon !== 1'b0) begin
            bad++;
            $display("FAIL flush_%0d: valid=%b on=%b, need 0 0", k, pov, pon);
         end
      end
      send(0, 0, 1'b0, 1'b0);
      idle();
      send(0, 0, 1'b1, 1'b1);
      idle();

      // Non-zero origin instance: no underflow left of the origin
      send2(99, 0, 1'b0);
      send2(100, 0, 1'b1);
      send2(156, 0, 1'b0);
      idle();

      for (int i = 0; i < 20 && (q1.size() > 0 || q2.size() > 0); i++) @(posedge clk);
      total++;
      if (q1.size() > 0 || q2.size() > 0) begin
         bad++;
         $display("FAIL drain: %0d/%0d outputs outstanding, need 0/0", q1.size(), q2.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
